// File: rtl/mem_responder_if.sv
// Request/response bundle between the CPU datapath (master) and the memory responder (slave).
interface mem_responder_if #(
  parameter int DATA_BIT = 16,
  parameter int ADDR_BIT = 8
);
  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [ADDR_BIT-1:0] req_addr;
  logic [DATA_BIT-1:0] req_wdata;
  logic                resp_valid;
  logic                resp_ready;
  logic                resp_we;
  logic [DATA_BIT-1:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_we, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_we, resp_rdata
  );
endinterface

// File: rtl/mem_responder.sv
// Single-port word memory answering one load/store request at a time,
// with WAIT wait states between acceptance and response.
//
// state  | meaning
// S_IDLE | ready for a request (req_ready=1 once out of reset)
// S_WAIT | request latched, counting wait states; access on cnt==0
// S_RESP | response presented, held until resp_ready
module mem_responder #(
  parameter int DATA_BIT = 16,
  parameter int ADDR_BIT = 8,
  parameter int WAIT     = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,    // synchronous, active-low
  mem_responder_if.slave  io_bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  // The counter also covers the access cycle, so S_WAIT lasts WAIT+1 cycles
  // and the response appears WAIT+1 edges after acceptance (also for WAIT=0).
  localparam logic [3:0] CNT_LOAD = 4'(WAIT);

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_we;
  logic [ADDR_BIT-1:0] r_addr;
  logic [DATA_BIT-1:0] r_wdata;
  logic                r_req_ready;
  logic                r_resp_valid;
  logic                r_resp_we;
  logic [DATA_BIT-1:0] r_resp_rdata;
  logic [DATA_BIT-1:0] r_mem [0:(1<<ADDR_BIT)-1];

  logic w_accept;
  logic w_access;
  logic w_store;

  assign w_accept = (r_state == S_IDLE) && r_req_ready && io_bus.req_valid;
  assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);
  // Reset wins over the access, so an abandoned store never reaches the array.
  assign w_store  = i_rst && w_access && r_we;

  // Memory array: written once on the access edge of a store, never cleared.
  always_ff @(posedge i_clk) begin
    if (w_store) r_mem[r_addr] <= r_wdata;
  end

  // Request/response sequencing with registered handshake and data outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_we    <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          if (w_accept) begin
            r_we        <= io_bus.req_we;
            r_addr      <= io_bus.req_addr;
            r_wdata     <= io_bus.req_wdata;
            r_req_ready <= 1'b0;
            r_cnt       <= CNT_LOAD;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_resp_rdata <= r_we ? r_wdata : r_mem[r_addr];
            r_resp_we    <= r_we;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (io_bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.req_ready  = r_req_ready;
  assign io_bus.resp_valid = r_resp_valid;
  assign io_bus.resp_we    = r_resp_we;
  assign io_bus.resp_rdata = r_resp_rdata;

endmodule
